// File: rtl/qlearn_pkg.sv
// rtl/qlearn_pkg.sv - shared Q-learning types, widths and address packing
//
// Purpose: common definitions for the Q-table update pipeline and the policy
// reader: table geometry, action encoding, reader FSM states and the
// {state, action} address packing used by both sides of the table.
// Ports: none (package).

package qlearn_pkg;

   localparam int STATE_BITS  = 6;
   localparam int ACTION_BITS = 2;
   localparam int ADDR_BITS   = STATE_BITS + ACTION_BITS;

   typedef enum logic [ACTION_BITS-1:0] {
      ACT_LEFT  = 2'd0,
      ACT_UP    = 2'd1,
      ACT_RIGHT = 2'd2,
      ACT_DOWN  = 2'd3
   } action_t;

   typedef enum logic [2:0] {
      RD_IDLE,
      RD_READ,
      RD_LAST,
      RD_OUT,
      RD_FIN
   } rd_state_t;

   function automatic logic [ADDR_BITS-1:0] pack_addr(
      input logic [STATE_BITS-1:0]  s,
      input logic [ACTION_BITS-1:0] a
   );
      return {s, a};
   endfunction

endpackage

// File: rtl/qmax_argmax.sv
// rtl/qmax_argmax.sv - sequential running max / argmax accumulator
//
// Purpose: tracks the largest value seen in a sequence and the index it
// arrived with. init restarts the sequence with the presented value; later
// values replace the best only when strictly greater, so ties keep the
// earliest (lowest) index.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   init              first element of a new sequence (qualified by en)
//   en                value/idx are valid this cycle
//   value, idx        candidate value and its index
//   best_val, best_idx  registered running maximum and its index

module qmax_argmax #(
   parameter int DATA_WIDTH = 8,
   parameter int IDX_BITS   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  init,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] value,
   input  logic [IDX_BITS-1:0]   idx,
   output logic [DATA_WIDTH-1:0] best_val,
   output logic [IDX_BITS-1:0]   best_idx
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best_val <= '0;
         best_idx <= '0;
      end else if (en && (init || (value > best_val))) begin
         best_val <= value;
         best_idx <= idx;
      end
   end

endmodule

// File: rtl/q_policy_reader.sv
// rtl/q_policy_reader.sv - Q-table scan producing one greedy-action record per state
//
// Purpose: on start, reads the four action values of every state through a
// one-cycle-latency read port, finds the greedy action and streams
// {state, action, qmax} records over a valid/ready handshake.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   start                        begin a scan (sampled only when idle)
//   busy, done                   scan in progress / one-cycle completion pulse
//   mem_rd, mem_addr, mem_rdata  Q-table read port, data one cycle after mem_rd
//   pol_valid, pol_ready         record handshake
//   pol_state, pol_action, pol_qmax  record payload

module q_policy_reader #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int STATE_BITS  = qlearn_pkg::STATE_BITS,
   parameter int ACTION_BITS = qlearn_pkg::ACTION_BITS
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   mem_rd,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   input  logic [DATA_WIDTH-1:0]  mem_rdata,
   output logic                   pol_valid,
   input  logic                   pol_ready,
   output logic [STATE_BITS-1:0]  pol_state,
   output logic [ACTION_BITS-1:0] pol_action,
   output logic [DATA_WIDTH-1:0]  pol_qmax
);

   localparam logic [ACTION_BITS-1:0] A_ONE = 1;

   qlearn_pkg::rd_state_t st;

   logic [STATE_BITS-1:0]  s;       // state being scanned
   logic [ACTION_BITS-1:0] a;       // next action to issue; 0 means all four issued
   logic                   rvalid;  // mem_rdata holds data for the previous read
   logic [ACTION_BITS-1:0] ridx;    // action index of that returning data

   // The state counter is only advanced after a record is accepted, so it
   // doubles as the record's state field.
   assign pol_state = s;

   // The accumulator registers are the action/qmax outputs: they settle with
   // the LAST compare, exactly when pol_valid rises, and hold through OUT
   // because no read data is qualified there.
   qmax_argmax #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_BITS   (ACTION_BITS)
   ) u_argmax (
      .clk      (clk),
      .rst_n    (rst_n),
      .init     (ridx == '0),
      .en       (rvalid),
      .value    (mem_rdata),
      .idx      (ridx),
      .best_val (pol_qmax),
      .best_idx (pol_action)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= qlearn_pkg::RD_IDLE;
         s         <= '0;
         a         <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_rd    <= 1'b0;
         mem_addr  <= '0;
         pol_valid <= 1'b0;
         rvalid    <= 1'b0;
         ridx      <= '0;
      end else begin
         rvalid <= mem_rd;
         ridx   <= mem_addr[ACTION_BITS-1:0];
         done   <= 1'b0;
         case (st)
            qlearn_pkg::RD_IDLE: begin
               if (start) begin
                  st       <= qlearn_pkg::RD_READ;
                  busy     <= 1'b1;
                  s        <= '0;
                  a        <= A_ONE;
                  mem_rd   <= 1'b1;
                  mem_addr <= qlearn_pkg::pack_addr('0, '0);
               end
            end
            qlearn_pkg::RD_READ: begin
               if (a == '0) begin
                  mem_rd <= 1'b0;
                  st     <= qlearn_pkg::RD_LAST;
               end else begin
                  mem_addr <= qlearn_pkg::pack_addr(s, a);
                  a        <= a + 1'b1;
               end
            end
            qlearn_pkg::RD_LAST: begin
               pol_valid <= 1'b1;
               st        <= qlearn_pkg::RD_OUT;
            end
            qlearn_pkg::RD_OUT: begin
               if (pol_ready) begin
                  pol_valid <= 1'b0;
                  if (s == '1) begin
                     done <= 1'b1;
                     st   <= qlearn_pkg::RD_FIN;
                  end else begin
                     s        <= s + 1'b1;
                     a        <= A_ONE;
                     mem_rd   <= 1'b1;
                     mem_addr <= qlearn_pkg::pack_addr(s + 1'b1, '0);
                     st       <= qlearn_pkg::RD_READ;
                  end
               end
            end
            qlearn_pkg::RD_FIN: begin
               busy <= 1'b0;
               st   <= qlearn_pkg::RD_IDLE;
            end
            default: st <= qlearn_pkg::RD_IDLE;
         endcase
      end
   end

endmodule
